// File: rtl/adapter_dl_scheduler.sv
// Downlink adapter sequencer: one frame-aligned FSM that paces capture, lane shifting
// and FIFO reads, and latches sticky overflow/underflow from the FIFO fill level.
module adapter_dl_scheduler #(
  parameter int LANES           = 8,
  parameter int SLOT_CYCLES     = 4,
  parameter int CAPTURE_OFFSET  = 18,
  parameter int PREFILL_WORDS   = 8,
  parameter int FIFO_ADDR_WIDTH = 4,
  localparam int LANE_W         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk_1,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     iq_rx_data_valid,
  input  logic [FIFO_ADDR_WIDTH:0] fifo_level,
  input  logic                     err_clear,
  output logic                     capture_stb,
  output logic                     shift_stb,
  output logic [LANE_W-1:0]        lane_sel,
  output logic                     fifo_rd_stb,
  output logic                     running,
  output logic                     overflow_err,
  output logic                     underflow_err,
  output logic [2:0]               state
);

  localparam int FRAME_CYCLES = LANES * SLOT_CYCLES;
  localparam int FRAME_W      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int SLOT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  localparam logic [FRAME_W-1:0]         CAP_CNT     = FRAME_W'(CAPTURE_OFFSET);
  localparam logic [FRAME_W-1:0]         FRAME_LAST  = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [SLOT_W-1:0]          SLOT_LAST   = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0]          SHIFT_SLOT  = SLOT_W'(CAPTURE_OFFSET % SLOT_CYCLES);
  localparam logic [LANE_W-1:0]          LANE_LAST   = LANE_W'(LANES - 1);
  localparam logic [FIFO_ADDR_WIDTH:0]   FIFO_FULL   = (FIFO_ADDR_WIDTH+1)'(2**FIFO_ADDR_WIDTH);
  localparam logic [FIFO_ADDR_WIDTH:0]   PREFILL_LVL = (FIFO_ADDR_WIDTH+1)'(PREFILL_WORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ALIGN   = 3'd1,
    S_PREFILL = 3'd2,
    S_RUN     = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [SLOT_W-1:0]   r_rd_cnt;
  logic [LANE_W-1:0]   r_lane;
  logic                r_capture_stb;
  logic                r_shift_stb;
  logic                r_rd_stb;
  logic                r_running;
  logic                r_ovf;
  logic                r_unf;

  logic w_active;
  logic w_cap_due;
  logic w_shift_due;
  logic w_rd_due;
  logic w_ovf_hit;
  logic w_unf_hit;
  logic w_issue;

  // The slot counter runs in lockstep with the frame counter, so the shift phase
  // is a fixed slot index rather than a modulo of the frame count.
  always_comb begin
    w_active     = (r_state == S_ALIGN) || (r_state == S_PREFILL) || (r_state == S_RUN);
    w_cap_due    = w_active && (r_frame_cnt == CAP_CNT);
    w_shift_due  = ((r_state == S_PREFILL) || (r_state == S_RUN)) && (r_slot_cnt == SHIFT_SLOT);
    w_rd_due     = (r_state == S_RUN) && (r_rd_cnt == '0);
    w_ovf_hit    = w_shift_due && (fifo_level == FIFO_FULL);
    w_unf_hit    = w_rd_due && (fifo_level == '0);
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (iq_rx_data_valid) w_state_next = S_ALIGN;
      S_ALIGN:   if (w_cap_due) w_state_next = S_PREFILL;
      S_PREFILL: begin
        if (w_ovf_hit || w_unf_hit)       w_state_next = S_ERROR;
        else if (fifo_level >= PREFILL_LVL) w_state_next = S_RUN;
      end
      S_RUN:     if (w_ovf_hit || w_unf_hit) w_state_next = S_ERROR;
      S_ERROR:   if (err_clear) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (!enable) w_state_next = S_IDLE;
    w_issue = (w_state_next == S_PREFILL) || (w_state_next == S_RUN);
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= '0;
      r_slot_cnt    <= '0;
      r_rd_cnt      <= '0;
      r_lane        <= '0;
      r_capture_stb <= 1'b0;
      r_shift_stb   <= 1'b0;
      r_rd_stb      <= 1'b0;
      r_running     <= 1'b0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
    end else begin
      r_state <= w_state_next;

      // The aligning edge and any return to IDLE both zero the frame timing.
      if ((w_state_next == S_IDLE) || (r_state == S_IDLE)) begin
        r_frame_cnt <= '0;
        r_slot_cnt  <= '0;
      end else if (w_active && (w_state_next != S_ERROR)) begin
        r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
        r_slot_cnt  <= (r_slot_cnt == SLOT_LAST) ? '0 : r_slot_cnt + 1'b1;
      end

      if (r_state != S_RUN)
        r_rd_cnt <= '0;
      else if (w_state_next == S_RUN)
        r_rd_cnt <= (r_rd_cnt == SLOT_LAST) ? '0 : r_rd_cnt + 1'b1;

      if (w_state_next == S_IDLE)
        r_lane <= '0;
      else if (r_shift_stb)
        r_lane <= (r_lane == LANE_LAST) ? '0 : r_lane + 1'b1;

      r_capture_stb <= w_issue && w_cap_due;
      r_shift_stb   <= w_issue && w_shift_due && !w_ovf_hit;
      r_rd_stb      <= w_issue && w_rd_due && !w_unf_hit;
      r_running     <= (w_state_next == S_RUN);

      // A fresh error wins over a coincident clear so it is never lost.
      if (w_ovf_hit)      r_ovf <= 1'b1;
      else if (err_clear) r_ovf <= 1'b0;
      if (w_unf_hit)      r_unf <= 1'b1;
      else if (err_clear) r_unf <= 1'b0;
    end
  end

  assign capture_stb   = r_capture_stb;
  assign shift_stb     = r_shift_stb;
  assign lane_sel      = r_lane;
  assign fifo_rd_stb   = r_rd_stb;
  assign running       = r_running;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;
  assign state         = r_state;

endmodule

// File: tb/tb_adapter_dl_scheduler.sv
// Scoreboard bench: a frame-time reference model queues the expected outputs for each
// edge; a negedge monitor pops and compares them against the scheduler.
module tb_adapter_dl_scheduler;

  localparam int LANES = 8;
  localparam int SLOT  = 4;
  localparam int OFF   = 18;
  localparam int PW    = 8;
  localparam int AW    = 4;
  localparam int FRAME = LANES * SLOT;
  localparam int FULL  = 1 << AW;

  logic        clk_1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        iq_rx_data_valid = 1'b0;
  logic        err_clear = 1'b0;
  logic [AW:0] fifo_level = '0;
  logic        capture_stb, shift_stb, fifo_rd_stb, running, overflow_err, underflow_err;
  logic [2:0]  lane_sel;
  logic [2:0]  state;

  adapter_dl_scheduler #(
    .LANES(LANES), .SLOT_CYCLES(SLOT), .CAPTURE_OFFSET(OFF),
    .PREFILL_WORDS(PW), .FIFO_ADDR_WIDTH(AW)
  ) dut (
    .clk_1(clk_1), .rst_n(rst_n), .enable(enable), .iq_rx_data_valid(iq_rx_data_valid),
    .fifo_level(fifo_level), .err_clear(err_clear), .capture_stb(capture_stb),
    .shift_stb(shift_stb), .lane_sel(lane_sel), .fifo_rd_stb(fifo_rd_stb),
    .running(running), .overflow_err(overflow_err), .underflow_err(underflow_err),
    .state(state)
  );

  always #5 clk_1 = ~clk_1;

  typedef struct {
    logic [2:0] st;
    logic       cap, sh, rd, run, ovf, unf;
    logic [2:0] lane;
    logic       chk_lane;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: time since alignment drives all strobe timing.
  int m_st = 0, e_cnt = 0, t_align = 0, t_run = 0, lvl = 0, ovr = -1;
  bit m_ovf = 0, m_unf = 0, p_sh = 0, p_rd = 0;

  // DUT-side FIFO level seen by the monitor, for the steady-state window.
  int dut_lvl = 0, win_min = 1000, win_max = -1000;
  bit win_on = 0;

  initial begin : model
    exp_t x;
    int d, nx, fl, lane_i;
    bit en, v, ec, cap_due, sh_due, rd_due, ovf, unf, issue;
    forever begin
      @(posedge clk_1);
      e_cnt++;
      if (!rst_n) begin
        m_st = 0; m_ovf = 0; m_unf = 0; p_sh = 0; p_rd = 0; lvl = 0;
        x = '{st: 3'd0, cap: 1'b0, sh: 1'b0, rd: 1'b0, run: 1'b0, ovf: 1'b0, unf: 1'b0,
              lane: 3'd0, chk_lane: 1'b1};
      end else begin
        lvl = lvl + int'(p_sh) - int'(p_rd);
        if (lvl < 0) lvl = 0;
        if (lvl > FULL) lvl = FULL;
        en = enable; v = iq_rx_data_valid; ec = err_clear; fl = int'(fifo_level);
        cap_due = 0; sh_due = 0; rd_due = 0; lane_i = 0;
        if (m_st >= 1 && m_st <= 3) begin
          d = e_cnt - t_align;
          cap_due = (d >= OFF + 1) && (((d - (OFF + 1)) % FRAME) == 0);
          sh_due  = (m_st >= 2) && (((d - (OFF + 1)) % SLOT) == 0);
          if (sh_due) lane_i = ((d - (OFF + 1)) / SLOT - 1) % LANES;
          rd_due  = (m_st == 3) && (((e_cnt - t_run - 1) % SLOT) == 0);
        end
        ovf = sh_due && (fl == FULL);
        unf = rd_due && (fl == 0);
        case (m_st)
          0:       nx = v ? 1 : 0;
          1:       nx = cap_due ? 2 : 1;
          2:       nx = (ovf || unf) ? 4 : ((fl >= PW) ? 3 : 2);
          3:       nx = (ovf || unf) ? 4 : 3;
          default: nx = ec ? 0 : 4;
        endcase
        if (!en) nx = 0;
        if (m_st == 0 && nx == 1) t_align = e_cnt;
        if (m_st == 2 && nx == 3) t_run = e_cnt;
        issue = (nx == 2) || (nx == 3);
        if (ovf) m_ovf = 1; else if (ec) m_ovf = 0;
        if (unf) m_unf = 1; else if (ec) m_unf = 0;
        x.st   = 3'(nx);
        x.cap  = issue && cap_due;
        x.sh   = issue && sh_due && !ovf;
        x.rd   = issue && rd_due && !unf;
        x.run  = (nx == 3);
        x.ovf  = m_ovf;
        x.unf  = m_unf;
        x.lane = (nx == 0) ? 3'd0 : 3'(lane_i);
        x.chk_lane = x.sh || (nx == 0);
        p_sh = x.sh; p_rd = x.rd;
        if (nx == 0) lvl = 0;
        m_st = nx;
      end
      sb_q.push_back(x);
      #1;
      fifo_level = (ovr >= 0) ? (AW+1)'(ovr) : (AW+1)'(lvl);
    end
  end

  initial begin : monitor
    exp_t x;
    bit bad;
    forever begin
      @(negedge clk_1);
      if (state === 3'd0) dut_lvl = 0;
      else dut_lvl = dut_lvl + int'(shift_stb) - int'(fifo_rd_stb);
      if (win_on) begin
        if (dut_lvl < win_min) win_min = dut_lvl;
        if (dut_lvl > win_max) win_max = dut_lvl;
      end
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks++;
        bad = (state !== x.st) || (capture_stb !== x.cap) || (shift_stb !== x.sh) ||
              (fifo_rd_stb !== x.rd) || (running !== x.run) || (overflow_err !== x.ovf) ||
              (underflow_err !== x.unf) || (x.chk_lane && (lane_sel !== x.lane));
        if (bad) begin
          errors++;
          $display("FAIL sb edge %0d: got st=%0d cap=%0b sh=%0b lane=%0d rd=%0b run=%0b ovf=%0b unf=%0b, expected st=%0d cap=%0b sh=%0b lane=%0d%s rd=%0b run=%0b ovf=%0b unf=%0b",
                   e_cnt, state, capture_stb, shift_stb, lane_sel, fifo_rd_stb, running,
                   overflow_err, underflow_err, x.st, x.cap, x.sh, x.lane,
                   x.chk_lane ? "" : "(any)", x.rd, x.run, x.ovf, x.unf);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_1);
  endtask

  task automatic pulse_valid();
    iq_rx_data_valid = 1'b1; tick(1); iq_rx_data_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
  endtask

  initial begin : stim
    int r, ovr_len;
    ovr_len = 0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Nominal alignment, prefill and a long steady RUN with ignored valid pulses.
    enable = 1'b1;
    tick($urandom_range(0, 5));
    pulse_valid();
    tick(80);
    win_on = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      iq_rx_data_valid = ($urandom_range(0, 15) == 0);
      err_clear        = ($urandom_range(0, 63) == 0);
      tick(1);
    end
    iq_rx_data_valid = 1'b0; err_clear = 1'b0; win_on = 1'b0;
    checks++;
    if (win_min < 7 || win_max > 9) begin
      errors++;
      $display("FAIL steady_level: got min=%0d max=%0d, expected within 7..9", win_min, win_max);
    end
    checks++;
    if (overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL steady_flags: got ovf=%0b unf=%0b, expected 0 0", overflow_err, underflow_err);
    end

    // One-cycle enable drop in RUN, then re-alignment.
    enable = 1'b0; tick(1); enable = 1'b1;
    tick($urandom_range(3, 10));
    pulse_valid();
    tick(60);

    // Underflow in RUN.
    ovr = 0; tick(6); ovr = -1;
    tick(5);
    pulse_clear();
    tick(3);

    // Overflow during PREFILL.
    pulse_valid();
    tick(25);
    ovr = FULL; tick(6); ovr = -1;
    tick(5);
    pulse_clear();
    tick(3);

    // Asynchronous reset mid-frame.
    pulse_valid();
    tick(40);
    @(posedge clk_1);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if (state !== 3'd0 || capture_stb !== 1'b0 || shift_stb !== 1'b0 || fifo_rd_stb !== 1'b0 ||
        running !== 1'b0 || overflow_err !== 1'b0 || underflow_err !== 1'b0 || lane_sel !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d cap=%0b sh=%0b rd=%0b run=%0b ovf=%0b unf=%0b lane=%0d, expected all 0",
               state, capture_stb, shift_stb, fifo_rd_stb, running, overflow_err, underflow_err, lane_sel);
    end
    tick(3);
    rst_n = 1'b1;
    tick(20);
    pulse_valid();
    tick(60);

    // Randomized soak: realignments, enable drops, clears and forced full/empty levels.
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 999);
      iq_rx_data_valid = (r < 50);
      enable           = !(r >= 50 && r < 57);
      err_clear        = (r >= 57 && r < 67);
      if (r >= 67 && r < 72 && ovr < 0) begin
        ovr     = ($urandom_range(0, 1) != 0) ? FULL : 0;
        ovr_len = $urandom_range(1, 4);
      end
      tick(1);
      if (ovr >= 0) begin
        ovr_len--;
        if (ovr_len <= 0) ovr = -1;
      end
    end
    iq_rx_data_valid = 1'b0; err_clear = 1'b0; enable = 1'b1; ovr = -1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
